// File: rtl/ctrl_writeback_pkg.sv
// Shared types for the control writeback stage: the writeback packet, the
// captured recovery record and the recovery FSM state encoding.
package ctrl_writeback_pkg;

  localparam int SIZE_PC      = 32;
  localparam int SIZE_AL_LOG  = 7;
  localparam int SIZE_CTI_LOG = 4;
  localparam int SIZE_PHY_LOG = 7;
  localparam int SIZE_DATA    = 32;

  typedef struct packed {
    logic mispredict;
    logic destValid;
  } exeFlgs;

  typedef struct packed {
    logic                    valid;
    logic [SIZE_AL_LOG-1:0]  alID;
    logic [SIZE_CTI_LOG-1:0] ctiID;
    logic                    ctrlDir;
    logic [SIZE_PC-1:0]      nextPC;
    logic [SIZE_PHY_LOG-1:0] phyDest;
    logic [SIZE_DATA-1:0]    destData;
    exeFlgs                  flags;
  } wbPkt;

  typedef struct packed {
    logic [SIZE_PC-1:0]      pc;
    logic [SIZE_AL_LOG-1:0]  alID;
    logic [SIZE_CTI_LOG-1:0] ctiID;
  } recPkt;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } recStateE;

endpackage

// File: rtl/ctrl_writeback_if.sv
// Bundle between the control execute pipe / fetch and the writeback stage.
// master: the surrounding pipeline; slave: the writeback stage itself.
interface ctrl_writeback_if;
  import ctrl_writeback_pkg::*;

  wbPkt                    wbPacket_i;
  logic                    flush_i;
  logic [SIZE_AL_LOG-1:0]  alHead_i;
  logic                    recAck_i;

  logic                    alDoneValid_o;
  logic [SIZE_AL_LOG-1:0]  alDoneID_o;
  logic                    alDoneMisp_o;
  logic                    ctiValid_o;
  logic [SIZE_CTI_LOG-1:0] ctiID_o;
  logic                    ctiDir_o;
  logic [SIZE_PC-1:0]      ctiTarget_o;
  logic                    rfWrEn_o;
  logic [SIZE_PHY_LOG-1:0] rfWrAddr_o;
  logic [SIZE_DATA-1:0]    rfWrData_o;
  logic                    recReq_o;
  logic [SIZE_PC-1:0]      recPC_o;
  logic [SIZE_AL_LOG-1:0]  recAlID_o;
  logic [SIZE_CTI_LOG-1:0] recCtiID_o;

  modport master (
    output wbPacket_i, flush_i, alHead_i, recAck_i,
    input  alDoneValid_o, alDoneID_o, alDoneMisp_o,
    input  ctiValid_o, ctiID_o, ctiDir_o, ctiTarget_o,
    input  rfWrEn_o, rfWrAddr_o, rfWrData_o,
    input  recReq_o, recPC_o, recAlID_o, recCtiID_o
  );

  modport slave (
    input  wbPacket_i, flush_i, alHead_i, recAck_i,
    output alDoneValid_o, alDoneID_o, alDoneMisp_o,
    output ctiValid_o, ctiID_o, ctiDir_o, ctiTarget_o,
    output rfWrEn_o, rfWrAddr_o, rfWrData_o,
    output recReq_o, recPC_o, recAlID_o, recCtiID_o
  );

endinterface

// File: rtl/ctrl_writeback_al_age_compare.sv
// Older-than comparator on active-list IDs. Ages are taken relative to the
// list head modulo 2^W, so head wrap-around needs no special case.
module al_age_compare
  import ctrl_writeback_pkg::*;
#(
  parameter int W = SIZE_AL_LOG
) (
  input  logic [W-1:0] idA,
  input  logic [W-1:0] idB,
  input  logic [W-1:0] head,
  output logic         aOlder
);

  logic [W-1:0] ageA;
  logic [W-1:0] ageB;

  // modulo subtraction wraps naturally at width W
  always_comb begin
    ageA   = idA - head;
    ageB   = idB - head;
    aOlder = (ageA < ageB);
  end

endmodule

// File: rtl/ctrl_writeback.sv
// Control writeback stage: registers the control pipe packet, fans it out to
// the active list, CTI queue and register file, and holds the oldest
// outstanding mispredict for fetch until acknowledged.
//
// state | meaning
// IDLE  | no recovery outstanding
// PEND  | recReq asserted, rec* holds the oldest known mispredict
module ctrl_writeback
  import ctrl_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  ctrl_writeback_if.slave   bus
);

  wbPkt     wbReg;
  recPkt    recReg;
  recPkt    recNext;
  recPkt    recNew;
  recStateE state;
  recStateE stateNext;
  logic     newMisp;
  logic     newOlder;

  // stage register; flush kills whatever is being captured this edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wbReg <= '0;
    end else begin
      wbReg <= bus.wbPacket_i;
      if (bus.flush_i) wbReg.valid <= 1'b0;
    end
  end

  assign newMisp = wbReg.valid & wbReg.flags.mispredict;
  assign recNew  = '{pc: wbReg.nextPC, alID: wbReg.alID, ctiID: wbReg.ctiID};

  al_age_compare #(.W(SIZE_AL_LOG)) uAgeCmp (
    .idA    (wbReg.alID),
    .idB    (recReg.alID),
    .head   (bus.alHead_i),
    .aOlder (newOlder)
  );

  // recovery next-state: flush first, then an older mispredict, then ack
  always_comb begin
    stateNext = state;
    recNext   = recReg;
    case (state)
      IDLE: begin
        if (!bus.flush_i && newMisp) begin
          stateNext = PEND;
          recNext   = recNew;
        end
      end
      PEND: begin
        if (bus.flush_i) begin
          stateNext = IDLE;
        end else if (newMisp && newOlder) begin
          recNext   = recNew;
        end else if (bus.recAck_i) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // recovery state and captured branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      recReg <= '0;
    end else begin
      state  <= stateNext;
      recReg <= recNext;
    end
  end

  assign bus.alDoneValid_o = wbReg.valid;
  assign bus.alDoneID_o    = wbReg.valid ? wbReg.alID : '0;
  assign bus.alDoneMisp_o  = wbReg.valid & wbReg.flags.mispredict;
  assign bus.ctiValid_o    = wbReg.valid;
  assign bus.ctiID_o       = wbReg.valid ? wbReg.ctiID : '0;
  assign bus.ctiDir_o      = wbReg.valid & wbReg.ctrlDir;
  assign bus.ctiTarget_o   = wbReg.valid ? wbReg.nextPC : '0;
  assign bus.rfWrEn_o      = wbReg.valid & wbReg.flags.destValid;
  assign bus.rfWrAddr_o    = wbReg.valid ? wbReg.phyDest : '0;
  assign bus.rfWrData_o    = wbReg.valid ? wbReg.destData : '0;
  assign bus.recReq_o      = (state == PEND);
  assign bus.recPC_o       = recReg.pc;
  assign bus.recAlID_o     = recReg.alID;
  assign bus.recCtiID_o    = recReg.ctiID;

endmodule

// File: tb/tb_ctrl_writeback.sv
// Bench for ctrl_writeback: per-cycle scoreboard of fan-out outputs plus
// directed recovery-handshake checks.
module tb_ctrl_writeback;
  import ctrl_writeback_pkg::*;

  typedef struct packed {
    logic [8:0]  al;
    logic [37:0] cti;
    logic [39:0] rf;
  } expOut;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errCnt = 0;
  int   chkCnt = 0;
  expOut expQ[$];

  ctrl_writeback_if bus ();

  ctrl_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic wbPkt mkPkt(input logic misp, input logic destV,
                                 input logic [6:0] alID, input logic [3:0] ctiID,
                                 input logic dir, input logic [31:0] pc,
                                 input logic [6:0] phy, input logic [31:0] data);
    wbPkt p;
    p = '0;
    p.valid = 1'b1;
    p.flags.mispredict = misp;
    p.flags.destValid = destV;
    p.alID = alID;
    p.ctiID = ctiID;
    p.ctrlDir = dir;
    p.nextPC = pc;
    p.phyDest = phy;
    p.destData = data;
    return p;
  endfunction

  function automatic wbPkt misp(input logic [6:0] alID, input logic [31:0] pc);
    return mkPkt(1'b1, 1'b0, alID, alID[3:0], 1'b1, pc, 7'd0, 32'd0);
  endfunction

  // one clock: drive, push expectation, sample #1 after the edge, compare
  task automatic cycle(input wbPkt p, input logic fl, input logic ack);
    expOut e;
    bus.wbPacket_i = p;
    bus.flush_i = fl;
    bus.recAck_i = ack;
    e = '0;
    if (p.valid && !fl) begin
      e.al  = {1'b1, p.alID, p.flags.mispredict};
      e.cti = {1'b1, p.ctiID, p.ctrlDir, p.nextPC};
      e.rf  = p.flags.destValid ? {1'b1, p.phyDest, p.destData} : 40'd0;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    bus.wbPacket_i = '0;
    bus.flush_i = 1'b0;
    bus.recAck_i = 1'b0;
    if (expQ.size() == 0) begin
      errCnt++;
      $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
    end else begin
      e = expQ.pop_front();
      checkVal("alDone", 64'({bus.alDoneValid_o, bus.alDoneID_o, bus.alDoneMisp_o}), 64'(e.al));
      checkVal("cti", 64'({bus.ctiValid_o, bus.ctiID_o, bus.ctiDir_o, bus.ctiTarget_o}), 64'(e.cti));
      checkVal("rf", 64'({bus.rfWrEn_o, bus.rfWrAddr_o, bus.rfWrData_o}), 64'(e.rf));
    end
  endtask

  task automatic checkRec(input string tag, input logic req, input logic [6:0] alID, input logic [31:0] pc);
    checkVal({tag, ".recReq"}, 64'(bus.recReq_o), 64'(req));
    if (req) begin
      checkVal({tag, ".recAlID"}, 64'(bus.recAlID_o), 64'(alID));
      checkVal({tag, ".recPC"}, 64'(bus.recPC_o), 64'(pc));
      checkVal({tag, ".recCtiID"}, 64'(bus.recCtiID_o), 64'(alID[3:0]));
    end
  endtask

  initial begin
    bus.wbPacket_i = '0;
    bus.flush_i = 1'b0;
    bus.alHead_i = '0;
    bus.recAck_i = 1'b0;
    #12;
    checkVal("reset.alDone", 64'({bus.alDoneValid_o, bus.alDoneID_o, bus.alDoneMisp_o}), 64'd0);
    checkVal("reset.cti", 64'({bus.ctiValid_o, bus.ctiID_o, bus.ctiDir_o, bus.ctiTarget_o}), 64'd0);
    checkVal("reset.rf", 64'({bus.rfWrEn_o, bus.rfWrAddr_o, bus.rfWrData_o}), 64'd0);
    checkVal("reset.rec", 64'({bus.recReq_o, bus.recPC_o, bus.recAlID_o, bus.recCtiID_o}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle('0, 1'b0, 1'b0);

    // correctly predicted branch, then a link write
    cycle(mkPkt(1'b0, 1'b0, 7'd5, 4'd3, 1'b1, 32'h1040, 7'd0, 32'd0), 1'b0, 1'b0);
    checkRec("branch", 1'b0, 7'd0, 32'd0);
    cycle(mkPkt(1'b0, 1'b1, 7'd6, 4'd4, 1'b1, 32'h3000, 7'd12, 32'h2008), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("jal", 1'b0, 7'd0, 32'd0);

    // mispredict held for 5 cycles, then acked
    cycle(misp(7'd9, 32'h3000), 1'b0, 1'b0);
    checkRec("misp.lat", 1'b0, 7'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle('0, 1'b0, 1'b0);
      checkRec("misp.hold", 1'b1, 7'd9, 32'h3000);
    end
    cycle('0, 1'b0, 1'b1);
    checkRec("misp.ack", 1'b0, 7'd0, 32'd0);

    // replacement by an older branch across head=120
    bus.alHead_i = 7'd120;
    cycle(misp(7'd2, 32'h4002), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("repl.first", 1'b1, 7'd2, 32'h4002);
    cycle(misp(7'd125, 32'h4125), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("repl.older", 1'b1, 7'd125, 32'h4125);
    cycle(misp(7'd4, 32'h4004), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("repl.younger", 1'b1, 7'd125, 32'h4125);
    cycle('0, 1'b0, 1'b1);
    checkRec("repl.ack", 1'b0, 7'd0, 32'd0);

    // head wrap: 127 (age 1) beats 1 (age 3) at head=126
    bus.alHead_i = 7'd126;
    cycle(misp(7'd1, 32'h5001), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("wrap.first", 1'b1, 7'd1, 32'h5001);
    cycle(misp(7'd127, 32'h5127), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("wrap.older", 1'b1, 7'd127, 32'h5127);
    cycle('0, 1'b0, 1'b1);
    checkRec("wrap.ack", 1'b0, 7'd0, 32'd0);

    // ack together with a new mispredict, head=0
    bus.alHead_i = 7'd0;
    cycle(misp(7'd10, 32'h6010), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("simul.hold", 1'b1, 7'd10, 32'h6010);
    cycle(misp(7'd8, 32'h6008), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    checkRec("simul.older", 1'b1, 7'd8, 32'h6008);
    cycle(misp(7'd14, 32'h6014), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    checkRec("simul.younger", 1'b0, 7'd0, 32'd0);

    // flush over a valid input while pending, then flush beating a capture
    cycle(misp(7'd20, 32'h7020), 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    checkRec("flush.pend", 1'b1, 7'd20, 32'h7020);
    cycle(mkPkt(1'b1, 1'b1, 7'd21, 4'd5, 1'b1, 32'h7021, 7'd3, 32'h33), 1'b1, 1'b0);
    checkRec("flush.idle", 1'b0, 7'd0, 32'd0);
    cycle(misp(7'd22, 32'h7022), 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    checkRec("flush.nocap", 1'b0, 7'd0, 32'd0);
    cycle('0, 1'b0, 1'b0);
    checkRec("flush.after", 1'b0, 7'd0, 32'd0);

    // asynchronous reset while pending
    cycle(misp(7'd30, 32'h8030), 1'b0, 1'b0);
    cycle(mkPkt(1'b0, 1'b1, 7'd31, 4'd1, 1'b0, 32'h8031, 7'd9, 32'h99), 1'b0, 1'b0);
    checkRec("rst.pend", 1'b1, 7'd30, 32'h8030);
    #2;
    reset = 1'b0;
    #1;
    checkVal("rst.recReq", 64'(bus.recReq_o), 64'd0);
    checkVal("rst.rec", 64'({bus.recPC_o, bus.recAlID_o, bus.recCtiID_o}), 64'd0);
    checkVal("rst.alDone", 64'({bus.alDoneValid_o, bus.alDoneID_o}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cycle('0, 1'b0, 1'b0);
    checkRec("rst.after", 1'b0, 7'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
